// File: rtl/rom_ddr_loader_if.sv
// Cache-side DDR data port 1: one command per transfer, ready doubles as
// command accept and read-data valid.
interface rom_ddr_loader_if #(
    parameter int MEM_DW = 256,
    parameter int MEM_AW = 28
);
    logic [MEM_DW-1:0] mem_data_wr1;
    logic [MEM_DW-1:0] mem_data_rd1;
    logic [MEM_AW-1:0] mem_data_addr1;
    logic              mem_rw_data1;
    logic              mem_valid_data1;
    logic              mem_ready_data1;

    modport master (
        output mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
        input  mem_data_rd1, mem_ready_data1
    );

    modport slave (
        input  mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
        output mem_data_rd1, mem_ready_data1
    );
endinterface

// File: rtl/rom_ddr_loader.sv
// Streams a ROM image into DDR with each byte widened to a 32-bit lane, or
// reads the region back and counts mismatches against the ROM (verify pass).
module rom_ddr_loader #(
    parameter int               ROM_W     = 64,
    parameter int               ROM_AW    = 16,
    parameter int               NUM_WORDS = 38400,
    parameter int               ROM_LAT   = 1,
    parameter int               MEM_DW    = 256,
    parameter int               MEM_AW    = 28,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0,
    parameter int               ADDR_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [MEM_AW-1:0] first_err_addr,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    rom_ddr_loader_if.master  mem
);
    localparam int LANES = ROM_W / 8;
    localparam int LW    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [ROM_AW-1:0] LAST     = ROM_AW'((NUM_WORDS > 0) ? NUM_WORDS - 1 : 0);
    localparam logic [LW-1:0]     LAT_LAST = LW'(ROM_LAT - 1);

    typedef enum logic [2:0] {IDLE, ROM_RD, ISSUE, WAIT_RDY, FIN} state_e;

    function automatic logic [MEM_DW-1:0] expand(input logic [ROM_W-1:0] w);
        logic [MEM_DW-1:0] e;
        e = '0;
        for (int k = 0; k < LANES; k++) e[32*k +: 32] = {24'd0, w[8*k +: 8]};
        return e;
    endfunction

    state_e            state_q, state_d;
    logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [MEM_AW-1:0] first_err_q, first_err_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_W-1:0]  rom_word_q, rom_word_d;
    logic [MEM_DW-1:0] wr_q, wr_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              valid_q, valid_d;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        rom_addr_d  = rom_addr_q;
        rom_word_d  = rom_word_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: if (start) begin
                busy_d      = 1'b1;
                err_cnt_d   = '0;
                first_err_d = '0;
                if (NUM_WORDS > 0) begin
                    mode_d     = mode;
                    rw_d       = ~mode;
                    rom_addr_d = '0;
                    addr_d     = BASE_ADDR;
                    lat_cnt_d  = '0;
                    state_d    = ROM_RD;
                end else begin
                    state_d = FIN;
                end
            end
            ROM_RD: begin
                if (lat_cnt_q == LAT_LAST) state_d = ISSUE;
                else lat_cnt_d = lat_cnt_q + LW'(1);
            end
            // rom_data for the current address is valid this cycle.
            ISSUE: begin
                rom_word_d = rom_data;
                valid_d    = 1'b1;
                wr_d       = mode_q ? '0 : expand(rom_data);
                state_d    = WAIT_RDY;
            end
            WAIT_RDY: if (mem.mem_ready_data1) begin
                valid_d = 1'b0;
                wr_d    = '0;
                if (mode_q && (expand(rom_word_q) != mem.mem_data_rd1)) begin
                    if (err_cnt_q == '0) first_err_d = addr_q;
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                end
                if (rom_addr_q == LAST) begin
                    state_d = FIN;
                end else begin
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    addr_d     = addr_q + MEM_AW'(ADDR_STEP);
                    lat_cnt_d  = '0;
                    state_d    = ROM_RD;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            rom_addr_q  <= '0;
            rom_word_q  <= '0;
            wr_q        <= '0;
            addr_q      <= BASE_ADDR;
            rw_q        <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            rom_addr_q  <= rom_addr_d;
            rom_word_q  <= rom_word_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            valid_q     <= valid_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign err_cnt             = err_cnt_q;
    assign first_err_addr      = first_err_q;
    assign rom_addr            = rom_addr_q;
    assign mem.mem_data_wr1    = wr_q;
    assign mem.mem_data_addr1  = addr_q;
    assign mem.mem_rw_data1    = rw_q;
    assign mem.mem_valid_data1 = valid_q;
endmodule

// File: tb/tb_rom_ddr_loader.sv
// Randomized bench: a memory responder with random stalls plus a reference
// model of the expected command stream (addresses, widened data, error counts).
module tb_rom_ddr_loader;
    localparam int N = 6;
    localparam int LAT = 2;
    localparam logic [27:0] BASE = 28'hFFFFFF0;
    localparam int STEP = 8;

    logic clk = 1'b0;
    logic rst_n, start, mode, busy, done;
    logic [15:0] err_cnt;
    logic [27:0] first_err_addr;
    logic [15:0] rom_addr;
    logic [63:0] rom_data;

    logic start_z, mode_z, busy_z, done_z;
    logic [15:0] err_cnt_z, rom_addr_z;
    logic [27:0] first_err_z;

    rom_ddr_loader_if #(.MEM_DW(256), .MEM_AW(28)) mif ();
    rom_ddr_loader_if #(.MEM_DW(256), .MEM_AW(28)) mif_z ();

    rom_ddr_loader #(.ROM_W(64), .ROM_AW(16), .NUM_WORDS(N), .ROM_LAT(LAT), .MEM_DW(256),
                     .MEM_AW(28), .BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .rom_addr(rom_addr),
        .rom_data(rom_data), .mem(mif.master));

    rom_ddr_loader #(.NUM_WORDS(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .mode(mode_z), .busy(busy_z), .done(done_z),
        .err_cnt(err_cnt_z), .first_err_addr(first_err_z), .rom_addr(rom_addr_z),
        .rom_data(64'h0), .mem(mif_z.master));

    always #5 clk = ~clk;

    // Synchronous ROM with a two-stage output pipeline.
    logic [63:0] rom_mem [0:15];
    logic [63:0] rom_p1, rom_p2;
    always @(posedge clk) begin
        rom_p1 <= rom_mem[rom_addr[3:0]];
        rom_p2 <= rom_p1;
    end
    assign rom_data = rom_p2;

    int chk_cnt = 0, pass_cnt = 0;
    logic [27:0]  q_addr[$];
    logic         q_rw[$];
    logic [255:0] q_data[$];
    int done_cnt, done_c, stab_err, late_err, rom_err, busy_err, tot_stall;
    bit tmo;

    function automatic logic [255:0] exp_word(input logic [63:0] w);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = r | (256'((w >> (8 * k)) & 64'hFF) << (32 * k));
        return r;
    endfunction

    function automatic logic [27:0] exp_addr(input int i);
        longint a;
        a = longint'(BASE) + longint'(i) * STEP;
        return a[27:0];
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) rom_mem[i] = {$urandom, $urandom};
    endtask

    // Drives one pass and acts as the memory; records every accepted command.
    task automatic run_pass(input bit md, input int smin, input int smax,
                            input logic [31:0] flip_mask, input bit spam);
        bit in_cmd, prev_rdy;
        int stall, idx;
        logic [27:0] h_addr;
        logic h_rw;
        logic [255:0] h_data, flip;
        q_addr.delete(); q_rw.delete(); q_data.delete();
        done_cnt = 0; done_c = 0; stab_err = 0; late_err = 0; rom_err = 0;
        busy_err = 0; tot_stall = 0; in_cmd = 0; prev_rdy = 0; stall = 0;
        @(negedge clk); start = 1'b1; mode = md;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start = (spam && busy) ? 1'($urandom_range(1)) : 1'b0;
            if (spam) mode = 1'($urandom_range(1));
            if (c == 1 && busy !== 1'b1) busy_err++;
            if (done === 1'b1) begin done_cnt++; done_c = c; end
            if (rom_addr > 16'(N - 1)) rom_err++;
            if (prev_rdy && mif.mem_valid_data1 !== 1'b0) late_err++;
            prev_rdy = 0;
            if (mif.mem_valid_data1 === 1'b1) begin
                if (!in_cmd) begin
                    in_cmd = 1; h_addr = mif.mem_data_addr1; h_rw = mif.mem_rw_data1;
                    h_data = mif.mem_data_wr1;
                    stall = $urandom_range(smax, smin); tot_stall += stall;
                end else if (mif.mem_data_addr1 !== h_addr || mif.mem_rw_data1 !== h_rw ||
                             mif.mem_data_wr1 !== h_data) stab_err++;
                if (stall == 0) begin
                    idx = q_addr.size();
                    flip = 256'h1;
                    flip = flip << (idx * 32 + 3);
                    mif.mem_data_rd1 = exp_word(rom_mem[idx % 16]) ^ (flip_mask[idx % 32] ? flip : '0);
                    mif.mem_ready_data1 = 1'b1;
                    q_addr.push_back(h_addr); q_rw.push_back(h_rw); q_data.push_back(h_data);
                    in_cmd = 0; prev_rdy = 1;
                end else begin
                    mif.mem_ready_data1 = 1'b0; mif.mem_data_rd1 = {8{$urandom}}; stall--;
                end
            end else begin
                mif.mem_ready_data1 = 1'($urandom_range(1)); mif.mem_data_rd1 = {8{$urandom}};
            end
            if (done_cnt > 0 && c >= done_c + 3) break;
        end
        tmo = (done_cnt == 0);
        start = 1'b0; mif.mem_ready_data1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; start_z = 1'b0; mode_z = 1'b0;
        mif.mem_ready_data1 = 1'b0; mif.mem_data_rd1 = '0;
        mif_z.mem_ready_data1 = 1'b0; mif_z.mem_data_rd1 = '0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy, done}); else pass_cnt++;
        chk_cnt++; if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt: got %h want 0", err_cnt); else pass_cnt++;
        chk_cnt++; if (first_err_addr !== 28'h0) $display("FAIL reset_first_err: got %h want 0", first_err_addr); else pass_cnt++;
        chk_cnt++; if (rom_addr !== 16'h0) $display("FAIL reset_rom_addr: got %h want 0", rom_addr); else pass_cnt++;
        chk_cnt++; if (mif.mem_valid_data1 !== 1'b0) $display("FAIL reset_valid: got %b want 0", mif.mem_valid_data1); else pass_cnt++;
        chk_cnt++; if (mif.mem_rw_data1 !== 1'b1) $display("FAIL reset_rw: got %b want 1", mif.mem_rw_data1); else pass_cnt++;
        chk_cnt++; if (mif.mem_data_addr1 !== BASE) $display("FAIL reset_addr: got %h want %h", mif.mem_data_addr1, BASE); else pass_cnt++;
        chk_cnt++; if (mif.mem_data_wr1 !== '0) $display("FAIL reset_wr_data: got %h want 0", mif.mem_data_wr1); else pass_cnt++;
        // start coincident with reset must be dropped
        start = 1'b1;
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({busy, mif.mem_valid_data1} !== 2'b00) $display("FAIL reset_wins_start: got %b want 00", {busy, mif.mem_valid_data1}); else pass_cnt++;
    endtask

    task automatic test_write();
        logic [255:0] lit;
        fill_rom();
        rom_mem[0] = 64'h0102030405060708;
        lit = {32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07, 32'h08};
        run_pass(1'b0, 0, 2, 32'h0, 1'b0);
        chk_cnt++; if (tmo || done_cnt != 1) $display("FAIL write_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        chk_cnt++; if (q_addr.size() != N) $display("FAIL write_cmd_count: got %0d want %0d", q_addr.size(), N); else pass_cnt++;
        for (int i = 0; i < q_addr.size(); i++) begin
            chk_cnt++; if (q_addr[i] !== exp_addr(i)) $display("FAIL write_addr[%0d]: got %h want %h", i, q_addr[i], exp_addr(i)); else pass_cnt++;
            chk_cnt++; if (q_data[i] !== exp_word(rom_mem[i])) $display("FAIL write_data[%0d]: got %h want %h", i, q_data[i], exp_word(rom_mem[i])); else pass_cnt++;
            chk_cnt++; if (q_rw[i] !== 1'b1) $display("FAIL write_rw[%0d]: got %b want 1", i, q_rw[i]); else pass_cnt++;
        end
        chk_cnt++; if (q_data[0] !== lit) $display("FAIL write_byte_lanes: got %h want %h", q_data[0], lit); else pass_cnt++;
        chk_cnt++; if (busy_err + rom_err + late_err != 0) $display("FAIL write_protocol: got busy=%0d rom=%0d late=%0d want 0", busy_err, rom_err, late_err); else pass_cnt++;
        chk_cnt++; if (done_c != N * (2 + LAT) + tot_stall + 2) $display("FAIL write_latency: got %0d want %0d", done_c, N * (2 + LAT) + tot_stall + 2); else pass_cnt++;
    endtask

    task automatic test_stall();
        fill_rom();
        run_pass(1'b0, 5, 5, 32'h0, 1'b0);
        chk_cnt++; if (stab_err != 0) $display("FAIL stall_stable: got %0d changes want 0", stab_err); else pass_cnt++;
        chk_cnt++; if (late_err != 0) $display("FAIL stall_valid_drop: got %0d want 0", late_err); else pass_cnt++;
        chk_cnt++; if (q_addr.size() != N) $display("FAIL stall_cmd_count: got %0d want %0d", q_addr.size(), N); else pass_cnt++;
        for (int i = 0; i < q_addr.size(); i++) begin
            chk_cnt++; if (q_addr[i] !== exp_addr(i)) $display("FAIL stall_addr[%0d]: got %h want %h", i, q_addr[i], exp_addr(i)); else pass_cnt++;
        end
        chk_cnt++; if (done_c != N * (7 + LAT) + 2) $display("FAIL stall_latency: got %0d want %0d", done_c, N * (7 + LAT) + 2); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        fill_rom();
        run_pass(1'b0, 0, 0, 32'h0, 1'b0);
        chk_cnt++; if (done_c != N * (2 + LAT) + 2) $display("FAIL b2b_latency: got %0d want %0d", done_c, N * (2 + LAT) + 2); else pass_cnt++;
        chk_cnt++; if (q_addr.size() != N || late_err != 0) $display("FAIL b2b_cmds: got %0d late=%0d want %0d", q_addr.size(), late_err, N); else pass_cnt++;
    endtask

    task automatic test_verify();
        logic [31:0] mask;
        int exp_err, first;
        fill_rom();
        run_pass(1'b1, 0, 3, 32'h4, 1'b0);
        chk_cnt++; if (err_cnt !== 16'd1) $display("FAIL verify_err_cnt: got %0d want 1", err_cnt); else pass_cnt++;
        chk_cnt++; if (first_err_addr !== exp_addr(2)) $display("FAIL verify_first_err: got %h want %h", first_err_addr, exp_addr(2)); else pass_cnt++;
        chk_cnt++; if (q_addr.size() != N) $display("FAIL verify_cmd_count: got %0d want %0d", q_addr.size(), N); else pass_cnt++;
        for (int i = 0; i < q_addr.size(); i++) begin
            chk_cnt++; if (q_rw[i] !== 1'b0 || q_data[i] !== '0) $display("FAIL verify_read_cmd[%0d]: got rw=%b data=%h want rw=0 data=0", i, q_rw[i], q_data[i]); else pass_cnt++;
        end
        repeat (5) @(negedge clk);
        chk_cnt++; if (err_cnt !== 16'd1) $display("FAIL verify_err_hold: got %0d want 1", err_cnt); else pass_cnt++;
        // random error pattern, with start hammered while busy
        mask = $urandom_range(63, 1);
        exp_err = 0; first = -1;
        for (int i = 0; i < N; i++) if (mask[i]) begin exp_err++; if (first < 0) first = i; end
        fill_rom();
        run_pass(1'b1, 0, 2, mask, 1'b1);
        chk_cnt++; if (err_cnt !== 16'(exp_err)) $display("FAIL verify_rand_err: got %0d want %0d", err_cnt, exp_err); else pass_cnt++;
        chk_cnt++; if (first_err_addr !== exp_addr(first)) $display("FAIL verify_rand_first: got %h want %h", first_err_addr, exp_addr(first)); else pass_cnt++;
        chk_cnt++; if (done_cnt != 1 || q_addr.size() != N) $display("FAIL busy_start_ignored: got done=%0d cmds=%0d want 1/%0d", done_cnt, q_addr.size(), N); else pass_cnt++;
    endtask

    task automatic test_abort();
        int nv, extra_done;
        bit pv, hit;
        fill_rom();
        nv = 0; pv = 0; hit = 0; extra_done = 0;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); start = 1'b0;
            if (mif.mem_valid_data1 === 1'b1 && !pv) nv++;
            pv = mif.mem_valid_data1;
            if (nv == 3) begin hit = 1; break; end
            mif.mem_ready_data1 = mif.mem_valid_data1;
        end
        rst_n = 1'b0; mif.mem_ready_data1 = 1'b0;
        @(negedge clk);
        chk_cnt++; if (!hit) $display("FAIL abort_reach_third_cmd: got %0d cmds want 3", nv); else pass_cnt++;
        chk_cnt++; if ({mif.mem_valid_data1, busy, done} !== 3'b000) $display("FAIL abort_outputs: got %b want 000", {mif.mem_valid_data1, busy, done}); else pass_cnt++;
        chk_cnt++; if (mif.mem_data_addr1 !== BASE) $display("FAIL abort_addr: got %h want %h", mif.mem_data_addr1, BASE); else pass_cnt++;
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (done === 1'b1) extra_done++; end
        chk_cnt++; if (extra_done != 0) $display("FAIL abort_no_done: got %0d want 0", extra_done); else pass_cnt++;
        run_pass(1'b0, 0, 1, 32'h0, 1'b0);
        chk_cnt++; if (done_cnt != 1 || q_addr.size() != N) $display("FAIL abort_clean_pass: got done=%0d cmds=%0d want 1/%0d", done_cnt, q_addr.size(), N); else pass_cnt++;
        for (int i = 0; i < q_addr.size(); i++) begin
            chk_cnt++; if (q_data[i] !== exp_word(rom_mem[i])) $display("FAIL abort_pass_data[%0d]: got %h want %h", i, q_data[i], exp_word(rom_mem[i])); else pass_cnt++;
        end
    endtask

    task automatic test_zero_words();
        int dc, dfirst, nval;
        bit b1;
        dc = 0; dfirst = -1; nval = 0; b1 = 0;
        @(negedge clk); start_z = 1'b1; mode_z = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_z = busy_z;
            if (c == 1) b1 = busy_z;
            if (done_z === 1'b1) begin dc++; if (dfirst < 0) dfirst = c; end
            if (mif_z.mem_valid_data1 !== 1'b0) nval++;
        end
        start_z = 1'b0;
        chk_cnt++; if (dfirst != 2) $display("FAIL zero_done_delay: got %0d want 2", dfirst); else pass_cnt++;
        chk_cnt++; if (dc != 1) $display("FAIL zero_done_count: got %0d want 1", dc); else pass_cnt++;
        chk_cnt++; if (nval != 0) $display("FAIL zero_no_valid: got %0d want 0", nval); else pass_cnt++;
        chk_cnt++; if (b1 !== 1'b1) $display("FAIL zero_busy: got %b want 1", b1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_stall();
        test_back_to_back();
        test_verify();
        test_abort();
        test_zero_words();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
